// File: rtl/regfile_write_arbiter.sv
// Register-file write port arbiter: round-robin between two requesters,
// plus a clear engine that sweeps zeros into every register.
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_gnt,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_gnt,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t state;
    logic   last_gnt_b;

    // Grants depend only on registered state and current inputs.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!reset && state == IDLE && !clr_start) begin
            if (a_req && (!b_req || last_gnt_b))
                a_gnt = 1'b1;
            else if (b_req)
                b_gnt = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_gnt_b <= 1'b1;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            clr_busy   <= 1'b0;
            clr_done   <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state    <= CLEAR;
                        wr_en    <= 1'b1;
                        wr_addr  <= '0;
                        wr_data  <= '0;
                        clr_busy <= 1'b1;
                    end else if (a_gnt) begin
                        wr_en      <= 1'b1;
                        wr_addr    <= a_addr;
                        wr_data    <= a_data;
                        last_gnt_b <= 1'b0;
                    end else if (b_gnt) begin
                        wr_en      <= 1'b1;
                        wr_addr    <= b_addr;
                        wr_data    <= b_data;
                        last_gnt_b <= 1'b1;
                    end else begin
                        wr_en <= 1'b0;
                    end
                end
                CLEAR: begin
                    // wr_addr doubles as the sweep counter; it stops at the last register.
                    if (wr_addr == LAST_ADDR) begin
                        state    <= IDLE;
                        wr_en    <= 1'b0;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        wr_en   <= 1'b1;
                        wr_addr <= wr_addr + 1'b1;
                        wr_data <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    wr_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: stimulus queues expected writes,
// a negedge monitor pops and compares each write the DUT presents.
module tb_regfile_write_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clr_start = 1'b0;
    logic        clr_busy, clr_done;
    logic        a_req = 1'b0, b_req = 1'b0;
    logic [4:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_gnt, b_gnt;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   done_cnt = 0;

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) dut (
        .clock(clock), .reset(reset), .clr_start(clr_start),
        .clr_busy(clr_busy), .clr_done(clr_done),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_gnt(a_gnt),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_gnt(b_gnt),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_clear(input int n);
        for (int i = 0; i < n; i++) q.push_back('{addr: 5'(i), data: 32'h0, busy: 1'b1});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int d0;
        logic bad;

        fork
            forever begin
                @(negedge clock);
                if (a_gnt && b_gnt) chk("gnt_onehot", {a_gnt, b_gnt}, 2'b00);
                if (clr_done) done_cnt++;
                if (wr_en) begin
                    if (q.size() == 0) begin
                        chk("unexpected_write", {27'h0, wr_addr}, 64'hFFFF);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("wr_addr", {59'h0, wr_addr}, {59'h0, e.addr});
                        chk("wr_data", {32'h0, wr_data}, {32'h0, e.data});
                        chk("clr_busy", {63'h0, clr_busy}, {63'h0, e.busy});
                    end
                end
            end
        join_none

        // Reset state, with a request pending to confirm grants are masked.
        a_req = 1'b1;
        a_addr = 5'd9;
        step();
        step();
        chk("rst_a_gnt", {63'h0, a_gnt}, 64'h0);
        chk("rst_wr_en", {63'h0, wr_en}, 64'h0);
        chk("rst_wr_addr", {59'h0, wr_addr}, 64'h0);
        chk("rst_wr_data", {32'h0, wr_data}, 64'h0);
        chk("rst_busy", {63'h0, clr_busy}, 64'h0);
        chk("rst_done", {63'h0, clr_done}, 64'h0);
        reset = 1'b0;
        a_req = 1'b0;
        step();

        // A alone.
        a_req = 1'b1; a_addr = 5'd7; a_data = 32'hDEADBEEF;
        #1;
        chk("a_alone_a_gnt", {63'h0, a_gnt}, 64'h1);
        chk("a_alone_b_gnt", {63'h0, b_gnt}, 64'h0);
        q.push_back('{addr: 5'd7, data: 32'hDEADBEEF, busy: 1'b0});
        step();
        a_req = 1'b0;
        step();
        chk("a_alone_idle_wr_en", {63'h0, wr_en}, 64'h0);
        chk("a_alone_hold_addr", {59'h0, wr_addr}, 64'h7);
        chk("a_alone_hold_data", {32'h0, wr_data}, 64'hDEADBEEF);

        // Contention from reset: A,B,A,B.
        do_reset();
        a_req = 1'b1; a_addr = 5'd1; a_data = 32'h11111111;
        b_req = 1'b1; b_addr = 5'd2; b_data = 32'h22222222;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rr_a_gnt", {63'h0, a_gnt}, {63'h0, (i % 2 == 0)});
            chk("rr_b_gnt", {63'h0, b_gnt}, {63'h0, (i % 2 == 1)});
            if (i % 2 == 0) q.push_back('{addr: 5'd1, data: 32'h11111111, busy: 1'b0});
            else            q.push_back('{addr: 5'd2, data: 32'h22222222, busy: 1'b0});
            step();
        end
        a_req = 1'b0; b_req = 1'b0;
        step();

        // Clear pulse: 32 writes then one clr_done cycle.
        clr_start = 1'b1;
        #1;
        chk("clr_start_gnt", {62'h0, a_gnt, b_gnt}, 64'h0);
        push_clear(32);
        step();
        clr_start = 1'b0;
        n = 0;
        while (!clr_done && n < 40) begin step(); n++; end
        chk("clr_len", 64'(n), 64'd32);
        chk("clr_done_wr_en", {63'h0, wr_en}, 64'h0);
        chk("clr_done_busy", {63'h0, clr_busy}, 64'h0);
        step();
        chk("clr_done_pulse", {63'h0, clr_done}, 64'h0);

        // Clear versus request from B.
        clr_start = 1'b1;
        b_req = 1'b1; b_addr = 5'd3; b_data = 32'h55;
        #1;
        chk("clrb_start_b_gnt", {63'h0, b_gnt}, 64'h0);
        push_clear(32);
        step();
        clr_start = 1'b0;
        n = 0;
        bad = 1'b0;
        while (!clr_done && n < 40) begin
            if (b_gnt) bad = 1'b1;
            step();
            n++;
        end
        chk("clrb_wait_b_gnt", {63'h0, bad}, 64'h0);
        chk("clrb_len", 64'(n), 64'd32);
        chk("clrb_done_b_gnt", {63'h0, b_gnt}, 64'h1);
        q.push_back('{addr: 5'd3, data: 32'h55, busy: 1'b0});
        step();
        b_req = 1'b0;
        step();

        // Reset in the middle of a clear.
        d0 = done_cnt;
        clr_start = 1'b1;
        push_clear(11);
        step();
        clr_start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("mid_wr_addr10", {59'h0, wr_addr}, 64'd10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_wr_en", {63'h0, wr_en}, 64'h0);
        chk("mid_busy", {63'h0, clr_busy}, 64'h0);
        chk("mid_wr_addr", {59'h0, wr_addr}, 64'h0);
        for (int i = 0; i < 30; i++) step();
        chk("mid_no_done", 64'(done_cnt - d0), 64'd0);

        // Re-trigger while busy.
        d0 = done_cnt;
        clr_start = 1'b1;
        push_clear(32);
        step();
        clr_start = 1'b0;
        n = 0;
        while (!clr_done && n < 40) begin
            step();
            n++;
            clr_start = (n == 5);
        end
        clr_start = 1'b0;
        chk("retrig_len", 64'(n), 64'd32);
        for (int i = 0; i < 5; i++) step();
        chk("retrig_one_done", 64'(done_cnt - d0), 64'd1);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, data width of the register-file write port.
REQ-002 Parameter ADDR_W, default 5, register address width.
REQ-003 Parameter NREGS, default 32, number of registers swept by a clear; SHALL equal 2**ADDR_W.
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  reset is synchronous and active-high.
REQ-006 clr_start  in  1  request to zero all NREGS registers; level sampled each edge.
REQ-007 clr_busy  out  1  high while the clear sweep is issuing writes.
REQ-008 clr_done  out  1  one-cycle pulse after the last clear write.
REQ-009 a_req, a_addr[ADDR_W], a_data[DATA_W]  in  requester A (pipeline writeback).
REQ-010 a_gnt  out  1  combinational grant to A.
REQ-011 b_req, b_addr[ADDR_W], b_data[DATA_W]  in  requester B (load/debug port).
REQ-012 b_gnt  out  1  combinational grant to B.
REQ-013 wr_en  out  1  registered write enable to the register file.
REQ-014 wr_addr  out  ADDR_W  registered write address.
REQ-015 wr_data  out  DATA_W  registered write data.

Function
REQ-016 FSM states IDLE and CLEAR; transfers are arbitrated only in IDLE.
REQ-017 A transfer occurs on an edge where x_req=1 and x_gnt=1; the requester holds req/addr/data stable until that edge.
REQ-018 A transfer at edge E drives wr_en=1, wr_addr=x_addr, wr_data=x_data in the cycle after E (latency 1).
REQ-019 No transfer at edge E: wr_en=0 after E; wr_addr/wr_data hold their previous values.
REQ-020 At most one of a_gnt, b_gnt is high in any cycle.
REQ-021 Single requester in IDLE with clr_start=0: that requester is granted in the same cycle.
REQ-022 Both requesting: grant goes to the requester not granted most recently (round-robin); last-grant pointer updates only on a transfer.
REQ-023 Last-grant pointer resets to B, so A wins the first contention.
REQ-024 In IDLE, clr_start=1 has priority: a_gnt=b_gnt=0 that cycle; the state enters CLEAR at the next edge.
REQ-025 The entering edge E0 loads wr_en=1, wr_addr=0, wr_data=0, clr_busy=1.
REQ-026 Each subsequent edge in CLEAR increments wr_addr by 1, with wr_data=0 and wr_en=1.
REQ-027 The edge after wr_addr reaches NREGS-1 returns the FSM to IDLE with wr_en=0 and clr_busy=0.
REQ-028 That same edge sets clr_done=1 for exactly one cycle; the sweep is exactly NREGS write cycles.
REQ-029 The address counter does not wrap past NREGS-1.
REQ-030 In CLEAR, a_gnt=b_gnt=0 regardless of requests; pending requests wait, are not dropped, and are arbitrated in the first IDLE cycle (the clr_done cycle).
REQ-031 clr_start asserted during CLEAR is ignored and does not restart or extend the sweep.
REQ-032 clr_start held high continuously starts a new sweep from the clr_done cycle; no grants are issued while it stays high.
REQ-033 Arbitration, grants and FSM use only registered state plus current inputs; there are no combinational paths from wr_* back to the grants.

Reset
REQ-034 reset=1 at an edge forces IDLE, wr_en=0, wr_addr=0, wr_data=0, clr_busy=0, clr_done=0, address counter 0, last-grant pointer=B.
REQ-035 reset has priority over clr_start and all requests; a_gnt=b_gnt=0 in any cycle where reset=1.
REQ-036 reset during CLEAR aborts the sweep immediately; no clr_done pulse is produced; remaining registers are not written.

Verification
REQ-037 A alone: a_req=1, a_addr=7, a_data=0xDEADBEEF for one cycle -> a_gnt=1 the same cycle; next cycle wr_en=1, wr_addr=7, wr_data=0xDEADBEEF; following cycle wr_en=0.
REQ-038 Contention: a_req and b_req both held high for 4 cycles after reset -> grants alternate A,B,A,B; the wr_addr sequence matches; a_gnt and b_gnt are never both 1.
REQ-039 Clear: clr_start pulsed one cycle in IDLE -> 32 consecutive cycles wr_en=1, wr_addr 0..31, wr_data=0, clr_busy=1; then clr_done=1 for one cycle with wr_en=0.
REQ-040 Clear vs request: b_req=1 (addr 3, data 0x55) raised in the same cycle as clr_start -> b_gnt=0 throughout the sweep; b_gnt=1 in the clr_done cycle; write to addr 3 appears the next cycle.
REQ-041 Reset mid-clear: reset=1 when wr_addr=10 -> next cycle wr_en=0, clr_busy=0, wr_addr=0; clr_done is never asserted.
REQ-042 Re-trigger: clr_start pulsed while clr_busy=1 -> the sweep still ends after exactly 32 writes; only one clr_done pulse occurs.
